instr_mem_ctrl: RTL

INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

---
 rtl/instr_mem_ctrl_pkg.sv | 13 +
 rtl/imem_ram.sv | 25 ++
 rtl/instr_mem_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/instr_mem_ctrl_pkg.sv
// Shared types and constants for the instruction memory controller:
// controller state encoding and default storage depth.
package instr_mem_ctrl_pkg;

  localparam int DEPTH_LOG2_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous word RAM: one write or one read per cycle, read data
// registered (1-cycle latency) and held until the next read.
module imem_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_reg [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[addr] <= wdata;
    end else if (en) begin
      rdata <= mem_reg[addr];
    end
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: byte-stream program loader plus valid/ready
// fetch port. Define IMEM_BOUNDS_CHECK_EN to flag fetches at or beyond load_words.
module instr_mem_ctrl
  import instr_mem_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_ready,
  input  logic                  load_end,
  output logic                  load_ovf,
  output logic [DEPTH_LOG2:0]   load_words,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  input  logic                  rsp_ready,
  output logic                  rsp_err
);

  localparam logic [DEPTH_LOG2:0] FULL_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t              state_reg, state_next;
  logic [DEPTH_LOG2:0] wr_ptr_reg, wr_ptr_next;
  logic [1:0]          byte_cnt_reg, byte_cnt_next;
  logic [31:0]         word_buf_reg, word_buf_next;
  logic                load_ovf_reg, load_ovf_next;
  logic                rsp_valid_reg, rsp_valid_next;

  logic        full;
  logic        byte_fire;
  logic        byte_take;
  logic        word_wr;
  logic        req_fire;
  logic [31:0] word_asm;
  logic [31:0] ram_rdata;

  assign full       = (wr_ptr_reg == FULL_WORDS);
  assign load_ready = (state_reg == LOAD);
  assign byte_fire  = load_valid && load_ready;
  assign byte_take  = byte_fire && !full;
  assign req_ready  = (state_reg == RUN) && (!rsp_valid_reg || rsp_ready);
  assign req_fire   = req_valid && req_ready;

  assign load_ovf   = load_ovf_reg;
  assign load_words = wr_ptr_reg;
  assign rsp_valid  = rsp_valid_reg;

  // Unfilled lanes of word_buf_reg are kept zero, so a partial word needs no masking.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_asm[8*gi +: 8] = (byte_take && byte_cnt_reg == 2'(gi)) ? load_byte
                                                                       : word_buf_reg[8*gi +: 8];
  end

  assign word_wr = (state_reg == LOAD) && !load_start && !full &&
                   ((byte_take && byte_cnt_reg == 2'd3) ||
                    (load_end && (byte_cnt_reg != 2'd0 || byte_take)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      byte_cnt_reg  <= '0;
      word_buf_reg  <= '0;
      load_ovf_reg  <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      byte_cnt_reg  <= byte_cnt_next;
      word_buf_reg  <= word_buf_next;
      load_ovf_reg  <= load_ovf_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    byte_cnt_next  = byte_cnt_reg;
    word_buf_next  = word_buf_reg;
    load_ovf_next  = load_ovf_reg;
    rsp_valid_next = rsp_valid_reg;
    if (load_start) begin
      state_next     = LOAD;
      wr_ptr_next    = '0;
      byte_cnt_next  = '0;
      word_buf_next  = '0;
      load_ovf_next  = 1'b0;
      rsp_valid_next = 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (byte_fire && full) load_ovf_next = 1'b1;
          if (byte_take) begin
            byte_cnt_next = byte_cnt_reg + 2'd1;
            word_buf_next = word_asm;
          end
          if (word_wr) begin
            wr_ptr_next   = wr_ptr_reg + 1'b1;
            word_buf_next = '0;
          end
          if (load_end) begin
            state_next    = RUN;
            byte_cnt_next = '0;
            word_buf_next = '0;
          end
        end
        RUN: begin
          if (req_fire) begin
            rsp_valid_next = 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_next = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Loading only happens in LOAD and fetching only in RUN, so the port never conflicts.
  imem_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (32)
  ) u_ram (
    .clk   (clk),
    .we    (word_wr),
    .en    (req_fire),
    .addr  (word_wr ? wr_ptr_reg[DEPTH_LOG2-1:0] : req_addr[DEPTH_LOG2-1:0]),
    .wdata (word_asm),
    .rdata (ram_rdata)
  );

`ifdef IMEM_BOUNDS_CHECK_EN
  logic rsp_err_reg;
  logic addr_oob;

  assign addr_oob = (req_addr >= {{(31-DEPTH_LOG2){1'b0}}, wr_ptr_reg});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err_reg <= 1'b0;
    end else if (load_start) begin
      rsp_err_reg <= 1'b0;
    end else if (req_fire) begin
      rsp_err_reg <= addr_oob;
    end
  end

  assign rsp_err  = rsp_err_reg;
  assign rsp_data = (rsp_valid_reg && !rsp_err_reg) ? ram_rdata : 32'h0;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:DEPTH_LOG2];
  assign rsp_err  = 1'b0;
  assign rsp_data = rsp_valid_reg ? ram_rdata : 32'h0;
`endif

endmodule
